slv_guard_rst_ctrl: RTL and testbench

- Reset sequencer that sits directly downstream of the slave guard's reset request.
- On a guard reset request it isolates the monitored subordinate's AW/AR channels, drains outstanding transactions (bounded by a timeout), pulses a reset to the subordinate, waits a recovery period, then reopens traffic.
- Reports busy/done/timeout status back to the guard's rst_stat path.
- Observes AXI handshakes only; payload wiring stays outside the block.

---
 rtl/slv_guard_rst_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_slv_guard_rst_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_guard_rst_ctrl.sv
// slv_guard_rst_ctrl
// Reset sequencer placed after the slave guard's reset request. When a reset
// is requested it closes the AW/AR channels to the subordinate, lets
// outstanding transactions drain (bounded by drain_budget_i), pulses
// sub_rst_o for RstCycles, waits RecoverCycles, then reopens traffic.
// Only handshakes are observed; payload wiring stays outside this block.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rst_req_i                    reset request level from the guard
//   drain_budget_i               drain cycles allowed before a forced reset
//   mst_aw_valid_i/mst_aw_ready_o, slv_aw_valid_o/slv_aw_ready_i   AW gating
//   mst_ar_valid_i/mst_ar_ready_o, slv_ar_valid_o/slv_ar_ready_i   AR gating
//   b_valid_i/b_ready_i          B handshake (write completion)
//   r_valid_i/r_ready_i/r_last_i R handshake (read completion on last beat)
//   sub_rst_o                    reset to the subordinate
//   busy_o                       sequence in progress
//   rst_done_o                   one-cycle pulse when the sequence ends
//   drain_timeout_o              last drain ended by timeout (sticky)
module slv_guard_rst_ctrl #(
  parameter int MaxOutstanding = 16,
  parameter int CntWidth       = 10,
  parameter int RstCycles      = 8,
  parameter int RecoverCycles  = 4,
  parameter int OutCntWidth    = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rst_req_i,
  input  logic [CntWidth-1:0] drain_budget_i,
  input  logic                mst_aw_valid_i,
  output logic                mst_aw_ready_o,
  output logic                slv_aw_valid_o,
  input  logic                slv_aw_ready_i,
  input  logic                mst_ar_valid_i,
  output logic                mst_ar_ready_o,
  output logic                slv_ar_valid_o,
  input  logic                slv_ar_ready_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  output logic                sub_rst_o,
  output logic                busy_o,
  output logic                rst_done_o,
  output logic                drain_timeout_o
);

  localparam int PhMax = (RstCycles > RecoverCycles) ? RstCycles : RecoverCycles;
  localparam int PhW   = $clog2(PhMax + 1);

  localparam logic [OutCntWidth-1:0] CntMax  = OutCntWidth'(MaxOutstanding);
  localparam logic [PhW-1:0]         RstLast = PhW'(RstCycles - 1);
  localparam logic [PhW-1:0]         RecLast = PhW'(RecoverCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CntWidth-1:0]    r_timer;
  logic [PhW-1:0]         r_phase;
  logic                   r_sub_rst;
  logic                   r_done;
  logic                   r_timeout;
  logic [OutCntWidth-1:0] r_wr_cnt;
  logic [OutCntWidth-1:0] r_rd_cnt;
  logic                   r_aw_pend;
  logic                   r_ar_pend;

  logic w_aw_gate;
  logic w_ar_gate;
  logic w_aw_fire;
  logic w_ar_fire;
  logic w_b_fire;
  logic w_r_fire;
  logic w_drained;
  logic w_timer_hit;
  logic w_enter_reset;
  logic w_clear_track;

  // Channel gating: an address already presented to the subordinate keeps
  // its path open until accepted, so isolation never withdraws a valid.
  assign w_aw_gate = ((r_state != ST_IDLE) || (r_wr_cnt == CntMax)) && !r_aw_pend;
  assign w_ar_gate = ((r_state != ST_IDLE) || (r_rd_cnt == CntMax)) && !r_ar_pend;

  assign slv_aw_valid_o = mst_aw_valid_i & ~w_aw_gate;
  assign mst_aw_ready_o = slv_aw_ready_i & ~w_aw_gate;
  assign slv_ar_valid_o = mst_ar_valid_i & ~w_ar_gate;
  assign mst_ar_ready_o = slv_ar_ready_i & ~w_ar_gate;

  assign w_aw_fire = slv_aw_valid_o & slv_aw_ready_i;
  assign w_ar_fire = slv_ar_valid_o & slv_ar_ready_i;
  // Completions at a zero count are ignored so the counters cannot underflow.
  assign w_b_fire  = b_valid_i & b_ready_i & (r_wr_cnt != '0);
  assign w_r_fire  = r_valid_i & r_ready_i & r_last_i & (r_rd_cnt != '0);

  assign w_drained     = (r_wr_cnt == '0) && (r_rd_cnt == '0) && !r_aw_pend && !r_ar_pend;
  assign w_timer_hit   = (r_timer == drain_budget_i);
  assign w_enter_reset = (r_state == ST_ISOLATE) && (w_drained || w_timer_hit);
  // Tracking is wiped as RESET is entered and held at zero throughout RESET,
  // so anything the subordinate does while in reset is disregarded.
  assign w_clear_track = w_enter_reset || (r_state == ST_RESET);

  assign sub_rst_o       = r_sub_rst;
  assign busy_o          = (r_state != ST_IDLE);
  assign rst_done_o      = r_done;
  assign drain_timeout_o = r_timeout;

  // Outstanding transaction tracking
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear_track) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_aw_pend <= 1'b0;
      r_ar_pend <= 1'b0;
    end else begin
      case ({w_aw_fire, w_b_fire})
        2'b10:   if (r_wr_cnt != CntMax) r_wr_cnt <= r_wr_cnt + 1'b1;
        2'b01:   r_wr_cnt <= r_wr_cnt - 1'b1;
        default: r_wr_cnt <= r_wr_cnt;
      endcase
      case ({w_ar_fire, w_r_fire})
        2'b10:   if (r_rd_cnt != CntMax) r_rd_cnt <= r_rd_cnt + 1'b1;
        2'b01:   r_rd_cnt <= r_rd_cnt - 1'b1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      if (w_aw_fire)           r_aw_pend <= 1'b0;
      else if (slv_aw_valid_o) r_aw_pend <= 1'b1;
      if (w_ar_fire)           r_ar_pend <= 1'b0;
      else if (slv_ar_valid_o) r_ar_pend <= 1'b1;
    end
  end

  // Sequencer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_phase   <= '0;
      r_sub_rst <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rst_req_i) begin
            r_state   <= ST_ISOLATE;
            r_timer   <= '0;
            r_timeout <= 1'b0;
          end
        end
        ST_ISOLATE: begin
          // A clean drain wins over an expiring budget in the same cycle.
          if (w_drained) begin
            r_state   <= ST_RESET;
            r_sub_rst <= 1'b1;
            r_phase   <= '0;
          end else if (w_timer_hit) begin
            r_state   <= ST_RESET;
            r_sub_rst <= 1'b1;
            r_phase   <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESET: begin
          if (r_phase == RstLast) begin
            r_state   <= ST_RECOVER;
            r_sub_rst <= 1'b0;
            r_phase   <= '0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (r_phase == RecLast) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_sub_rst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Testbench for slv_guard_rst_ctrl: table-driven idle forwarding, hand-written
// multi-cycle sequences, and randomized traffic against a timeline model.
module tb_slv_guard_rst_ctrl;

  localparam int MaxOut = 2;
  localparam int CW     = 10;
  localparam int RC     = 8;
  localparam int RecC   = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          rst_req;
  logic [CW-1:0] budget;
  logic          aw_v, aw_r, s_aw_v, s_aw_r;
  logic          ar_v, ar_r, s_ar_v, s_ar_r;
  logic          b_v, b_r, r_v, r_r, r_l;
  logic          sub_rst, busy, done, tmo;

  always #5 clk = ~clk;

  slv_guard_rst_ctrl #(
    .MaxOutstanding(MaxOut),
    .CntWidth      (CW),
    .RstCycles     (RC),
    .RecoverCycles (RecC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .rst_req_i      (rst_req),
    .drain_budget_i (budget),
    .mst_aw_valid_i (aw_v),
    .mst_aw_ready_o (aw_r),
    .slv_aw_valid_o (s_aw_v),
    .slv_aw_ready_i (s_aw_r),
    .mst_ar_valid_i (ar_v),
    .mst_ar_ready_o (ar_r),
    .slv_ar_valid_o (s_ar_v),
    .slv_ar_ready_i (s_ar_r),
    .b_valid_i      (b_v),
    .b_ready_i      (b_r),
    .r_valid_i      (r_v),
    .r_ready_i      (r_r),
    .r_last_i       (r_l),
    .sub_rst_o      (sub_rst),
    .busy_o         (busy),
    .rst_done_o     (done),
    .drain_timeout_o(tmo)
  );

  int checks = 0;
  int errors = 0;

  // Timeline model: a sequence is described by the cycle it started and the
  // cycle its reset pulse began; phases follow from elapsed time.
  int now         = 0;
  int m_wr        = 0;
  int m_rd        = 0;
  bit m_awp       = 0;
  bit m_arp       = 0;
  bit m_in_seq    = 0;
  int m_seq_start = 0;
  int m_rst_at    = -1;
  int m_done_cyc  = -1;
  bit m_to        = 0;

  bit o_awv, o_awr, o_arv, o_arr, o_srst, o_busy, o_done, o_to;

  function automatic bit m_resetting();
    return m_in_seq && (m_rst_at >= 0) && (now >= m_rst_at) && (now < m_rst_at + RC);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0b expected %0b", name, now, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    bit g_aw, g_ar, aw_hs, ar_hs, b_hs, r_hs, drained;
    if (rst_i) begin
      m_wr = 0; m_rd = 0; m_awp = 0; m_arp = 0;
      m_in_seq = 0; m_rst_at = -1; m_done_cyc = -1; m_to = 0;
    end else begin
      g_aw    = (m_in_seq || m_wr == MaxOut) && !m_awp;
      g_ar    = (m_in_seq || m_rd == MaxOut) && !m_arp;
      aw_hs   = aw_v && s_aw_r && !g_aw;
      ar_hs   = ar_v && s_ar_r && !g_ar;
      b_hs    = b_v && b_r && (m_wr > 0);
      r_hs    = r_v && r_r && r_l && (m_rd > 0);
      drained = (m_wr == 0) && (m_rd == 0) && !m_awp && !m_arp;
      if (m_resetting()) begin
        m_wr = 0; m_rd = 0; m_awp = 0; m_arp = 0;
      end else begin
        m_wr  = m_wr + int'(aw_hs) - int'(b_hs);
        m_rd  = m_rd + int'(ar_hs) - int'(r_hs);
        m_awp = aw_hs ? 1'b0 : ((aw_v && !g_aw) ? 1'b1 : m_awp);
        m_arp = ar_hs ? 1'b0 : ((ar_v && !g_ar) ? 1'b1 : m_arp);
      end
      if (!m_in_seq) begin
        if (rst_req) begin
          m_in_seq = 1; m_seq_start = now + 1; m_rst_at = -1; m_to = 0;
        end
      end else if (m_rst_at < 0) begin
        if (drained || (now - m_seq_start == int'(budget))) begin
          m_rst_at = now + 1;
          if (!drained) m_to = 1;
          m_wr = 0; m_rd = 0; m_awp = 0; m_arp = 0;
        end
      end else if (now == m_rst_at + RC + RecC - 1) begin
        m_in_seq = 0; m_done_cyc = now + 1;
      end
    end
    now++;
  endtask

  // One clock cycle with the inputs currently driven: sample mid-cycle,
  // compare against the model, then advance the model at the edge.
  task automatic cyc();
    bit g_aw, g_ar;
    @(negedge clk);
    o_awv = s_aw_v; o_awr = aw_r; o_arv = s_ar_v; o_arr = ar_r;
    o_srst = sub_rst; o_busy = busy; o_done = done; o_to = tmo;
    if (!rst_i) begin
      g_aw = (m_in_seq || m_wr == MaxOut) && !m_awp;
      g_ar = (m_in_seq || m_rd == MaxOut) && !m_arp;
      check("model slv_aw_valid", o_awv, aw_v && !g_aw);
      check("model mst_aw_ready", o_awr, s_aw_r && !g_aw);
      check("model slv_ar_valid", o_arv, ar_v && !g_ar);
      check("model mst_ar_ready", o_arr, s_ar_r && !g_ar);
      check("model sub_rst", o_srst, m_resetting());
      check("model busy", o_busy, m_in_seq);
      check("model rst_done", o_done, !m_in_seq && (now == m_done_cyc));
      check("model drain_timeout", o_to, m_to);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    rst_req = 0; aw_v = 0; s_aw_r = 0; ar_v = 0; s_ar_r = 0;
    b_v = 0; b_r = 0; r_v = 0; r_r = 0; r_l = 0;
  endtask

  typedef struct {
    bit awv, sawr, bv, br;
    bit e_awv, e_awr;
  } vec_t;

  vec_t tbl[9];
  int iso_n, rst_n, rec_n, done_n;
  bit seen_rst;

  task automatic run_seq(input int len, input int b_at);
    iso_n = 0; rst_n = 0; rec_n = 0; done_n = 0; seen_rst = 0;
    for (int k = 0; k < len; k++) begin
      rst_req = (k == 0);
      b_v = (k == b_at); b_r = (k == b_at);
      cyc();
      if (o_srst) begin rst_n++; seen_rst = 1; end
      else if (o_busy && !seen_rst) iso_n++;
      else if (o_busy) rec_n++;
      if (o_done) done_n++;
    end
    clr();
  endtask

  initial begin
    clr();
    budget = 10'd100;
    rst_i  = 1;
    cyc(); cyc();
    rst_i = 0;
    cyc();
    check("reset sub_rst", o_srst, 1'b0);
    check("reset busy", o_busy, 1'b0);
    check("reset rst_done", o_done, 1'b0);
    check("reset drain_timeout", o_to, 1'b0);

    // Idle forwarding and write limit, table-driven
    tbl[0] = '{1, 1, 0, 0, 1, 1};
    tbl[1] = '{1, 1, 1, 1, 1, 1};
    tbl[2] = '{1, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 1, 0, 0, 1, 1};
    tbl[4] = '{1, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 1, 1, 0, 0};
    tbl[6] = '{0, 0, 1, 1, 0, 0};
    tbl[7] = '{1, 1, 0, 0, 1, 1};
    tbl[8] = '{0, 1, 1, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      aw_v = tbl[i].awv; s_aw_r = tbl[i].sawr; b_v = tbl[i].bv; b_r = tbl[i].br;
      cyc();
      check("tbl slv_aw_valid", o_awv, tbl[i].e_awv);
      check("tbl mst_aw_ready", o_awr, tbl[i].e_awr);
      check("tbl busy", o_busy, 1'b0);
    end
    clr();
    cyc();

    // Read limit: third AR blocked until one read completes
    ar_v = 1; s_ar_r = 1;
    cyc(); check("lim ar1", o_arv, 1'b1);
    cyc(); check("lim ar2", o_arv, 1'b1);
    cyc(); check("lim ar3 blocked", o_arv, 1'b0);
    r_v = 1; r_r = 1; r_l = 1;
    cyc(); check("lim ar3 during r", o_arv, 1'b0);
    r_v = 0; r_r = 0; r_l = 0;
    cyc(); check("lim ar3 passes", o_arv, 1'b1);
    clr();
    r_v = 1; r_r = 1; r_l = 1;
    cyc(); cyc();
    clr();
    cyc();

    // Clean drain: one write outstanding, B five cycles after the request
    aw_v = 1; s_aw_r = 1;
    cyc();
    clr();
    run_seq(40, 5);
    check_int("drain isolate cycles", iso_n, 6);
    check_int("drain reset cycles", rst_n, RC);
    check_int("drain recover cycles", rec_n, RecC);
    check_int("drain done pulses", done_n, 1);
    check("drain timeout flag", o_to, 1'b0);

    // Timeout: one read never completes
    budget = 10'd20;
    ar_v = 1; s_ar_r = 1;
    cyc();
    clr();
    run_seq(60, -1);
    check_int("tmo isolate cycles", iso_n, 21);
    check_int("tmo reset cycles", rst_n, RC);
    check_int("tmo done pulses", done_n, 1);
    check("tmo flag", o_to, 1'b1);
    // Read count was cleared by the reset: two ARs fit before the limit
    ar_v = 1; s_ar_r = 1;
    cyc(); check("tmo post ar1", o_arv, 1'b1);
    cyc(); check("tmo post ar2", o_arv, 1'b1);
    cyc(); check("tmo post ar3", o_arv, 1'b0);
    clr();
    r_v = 1; r_r = 1; r_l = 1;
    cyc(); cyc();
    clr();
    cyc();

    // Pending AW survives isolation
    budget = 10'd100;
    aw_v = 1; s_aw_r = 0; rst_req = 1;
    cyc(); check("pend aw idle", o_awv, 1'b1);
    rst_req = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("pend aw held", o_awv, 1'b1);
      check("pend busy", o_busy, 1'b1);
    end
    s_aw_r = 1;
    cyc(); check("pend aw accept", o_awr, 1'b1);
    cyc(); check("pend aw blocked", o_awv, 1'b0);
    clr();
    cyc(); check("pend still isolating", o_srst, 1'b0);
    b_v = 1; b_r = 1;
    cyc();
    clr();
    done_n = 0;
    for (int k = 0; k < 40 && done_n == 0; k++) begin
      cyc();
      if (o_done) done_n++;
    end
    check_int("pend done seen", done_n, 1);
    check("pend timeout flag", o_to, 1'b0);

    // rst_i while in RESET
    budget = 10'd0;
    aw_v = 1; s_aw_r = 1;
    cyc();
    clr();
    rst_req = 1;
    cyc();
    rst_req = 0;
    cyc();
    cyc();
    check("mid in reset", o_srst, 1'b1);
    check("mid timeout set", o_to, 1'b1);
    rst_i = 1;
    cyc();
    rst_i = 0;
    aw_v = 1; s_aw_r = 0;
    cyc();
    check("mid sub_rst", o_srst, 1'b0);
    check("mid busy", o_busy, 1'b0);
    check("mid timeout", o_to, 1'b0);
    check("mid gate open", o_awv, 1'b1);
    clr();
    cyc();

    // Randomized traffic against the model
    budget = 10'd5;
    for (int n = 0; n < 3000; n++) begin
      rst_i   = ($urandom_range(0, 999) == 0);
      rst_req = ($urandom_range(0, 29) == 0);
      if (!m_in_seq && $urandom_range(0, 9) == 0) budget = CW'($urandom_range(0, 30));
      aw_v = $urandom_range(0, 1); s_aw_r = $urandom_range(0, 1);
      ar_v = $urandom_range(0, 1); s_ar_r = $urandom_range(0, 1);
      b_v  = ($urandom_range(0, 3) == 0); b_r = $urandom_range(0, 1);
      r_v  = ($urandom_range(0, 2) == 0); r_r = $urandom_range(0, 1);
      r_l  = $urandom_range(0, 1);
      cyc();
    end
    rst_i = 0;
    clr();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
